// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// Provides default frame geometry, sample/index types, the ping-pong fill
// state encoding used by the output streamer, and a bit-reversal helper.
package fft_pkg;

   localparam int FFT_NPTS  = 64;
   localparam int FFT_WIDTH = 32;
   localparam int FFT_LOG2N = 6;

   typedef logic [FFT_WIDTH-1:0] sample_t;
   typedef logic [FFT_LOG2N-1:0] idx_t;

   // Number of complete frames held in the ping-pong store.
   typedef enum logic [1:0] {
      FILL_EMPTY = 2'd0,
      FILL_ONE   = 2'd1,
      FILL_TWO   = 2'd2
   } fill_t;

   function automatic idx_t bitrev(input idx_t k);
      idx_t r;
      for (int i = 0; i < FFT_LOG2N; i++) begin
         r[i] = k[FFT_LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// Combinational LOG2N-bit index reverser.
// Ports:
//   idx : index in natural order
//   rev : idx with its LOG2N bits reversed
module fft_bitrev_idx #(
   parameter int LOG2N = 6
) (
   input  logic [LOG2N-1:0] idx,
   output logic [LOG2N-1:0] rev
);

   for (genvar i = 0; i < LOG2N; i++) begin : g_rev
      assign rev[i] = idx[LOG2N-1-i];
   end

endmodule

// File: rtl/fft_out_streamer.sv
// FFT output streamer: captures whole NPTS-point frames from the wide
// parallel butterfly output into a two-frame ping-pong store and emits
// them one sample per cycle in natural bin order over valid/ready.
//
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   in_valid       : a frame is present on inpmac
//   in_ready       : a free slot exists (frame accepted on in_valid && in_ready)
//   inpmac         : frame, word k = inpmac[k*WIDTH +: WIDTH]
//   out_valid      : out_data holds a valid sample
//   out_ready      : downstream accepts the sample
//   out_data       : sample for bin out_index
//   out_index      : natural-order bin number of the current sample
//   out_last       : high on bin NPTS-1
//   frames_dropped : saturating count of in_valid cycles refused
//
// Fill-level FSM:
//   state      | meaning
//   FILL_EMPTY | no frame stored, output idle
//   FILL_ONE   | one frame stored, streaming it, one slot free
//   FILL_TWO   | both slots full, input refused
module fft_out_streamer
   import fft_pkg::*;
#(
   parameter int NPTS   = FFT_NPTS,
   parameter int WIDTH  = FFT_WIDTH,
   parameter int LOG2N  = FFT_LOG2N,
   parameter int BITREV = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NPTS*WIDTH-1:0] inpmac,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [LOG2N-1:0]      out_index,
   output logic                  out_last,
   output logic [7:0]            frames_dropped
);

   localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(NPTS-1);

   fill_t                  fill_q;
   fill_t                  fill_d;
   logic [NPTS*WIDTH-1:0]  buf0;
   logic [NPTS*WIDTH-1:0]  buf1;
   logic                   wsel;
   logic                   rsel;
   logic [LOG2N-1:0]       idx;
   logic [7:0]             drop_cnt;
   logic                   run_q;

   logic                   accept;
   logic                   emit;
   logic                   last_beat;
   logic [LOG2N-1:0]       rev_idx;
   logic [LOG2N-1:0]       rd_word;
   logic [NPTS*WIDTH-1:0]  rd_frame;

   // run_q keeps in_ready low while reset is held and until the first
   // clock after release, without routing the reset pin to an output.
   assign in_ready  = run_q && (fill_q != FILL_TWO);
   assign out_valid = (fill_q != FILL_EMPTY);
   assign out_index = idx;
   assign out_last  = out_valid && (idx == IDX_LAST);
   assign frames_dropped = drop_cnt;

   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;
   assign last_beat = emit && (idx == IDX_LAST);

   fft_bitrev_idx #(.LOG2N(LOG2N)) u_rev (
      .idx (idx),
      .rev (rev_idx)
   );

   // Input word k holds bin bitrev(k), so bin idx lives at word bitrev(idx).
   assign rd_word  = (BITREV != 0) ? rev_idx : idx;
   assign rd_frame = rsel ? buf1 : buf0;
   assign out_data = rd_frame[int'(rd_word)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_q <= FILL_EMPTY;
      end else begin
         fill_q <= fill_d;
      end
   end

   // An accept and a final beat in the same cycle cancel out.
   always_comb begin
      fill_d = fill_q;
      case (fill_q)
         FILL_EMPTY: begin
            if (accept) fill_d = FILL_ONE;
         end
         FILL_ONE: begin
            if (accept && !last_beat)      fill_d = FILL_TWO;
            else if (!accept && last_beat) fill_d = FILL_EMPTY;
         end
         FILL_TWO: begin
            if (last_beat) fill_d = FILL_ONE;
         end
         default: fill_d = FILL_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf0     <= '0;
         buf1     <= '0;
         wsel     <= 1'b0;
         rsel     <= 1'b0;
         idx      <= '0;
         drop_cnt <= '0;
         run_q    <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            if (wsel) buf1 <= inpmac;
            else      buf0 <= inpmac;
            wsel <= ~wsel;
         end
         if (emit) begin
            if (idx == IDX_LAST) begin
               idx  <= '0;
               rsel <= ~rsel;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule
